// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo datapath: operating modes, FSM states
// and the ASCII constants used by the case-folding transform.
package uart_pkg;

  localparam int unsigned MODE_BITS = 2;

  localparam logic [MODE_BITS-1:0] MODE_MANUAL = 2'd0;
  localparam logic [MODE_BITS-1:0] MODE_ECHO   = 2'd1;
  localparam logic [MODE_BITS-1:0] MODE_ADD    = 2'd2;
  localparam logic [MODE_BITS-1:0] MODE_UPPER  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_XFORM   = 3'd2,
    ST_WAIT_TX = 3'd3,
    ST_SEND    = 3'd4
  } state_t;

  localparam int unsigned ASCII_LOWER_A    = 32'h61;
  localparam int unsigned ASCII_LOWER_Z    = 32'h7A;
  localparam int unsigned ASCII_CASE_DELTA = 32'h20;

endpackage

// File: rtl/uart_echo_engine_byte_xform.sv
// Combinational per-word transform: identity, modular add of OFFSET, or
// lower-to-upper case folding of ASCII letters (only for words of 8+ bits).
module byte_xform
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned OFFSET    = 1
) (
  input  logic [MODE_BITS-1:0] i_mode,
  input  logic [DATA_BITS-1:0] i_byte,
  output logic [DATA_BITS-1:0] o_byte
);

  // Truncating the cast is exactly the modulo 2^DATA_BITS reduction.
  localparam logic [DATA_BITS-1:0] ADDEND   = DATA_BITS'(OFFSET);
  localparam bit                   UPPER_EN = (DATA_BITS >= 8);

  logic w_is_lower;

  always_comb begin
    w_is_lower = UPPER_EN
                 && (32'(i_byte) >= ASCII_LOWER_A)
                 && (32'(i_byte) <= ASCII_LOWER_Z);
    o_byte = i_byte;
    case (i_mode)
      MODE_ADD:   o_byte = i_byte + ADDEND;
      MODE_UPPER: begin
        if (w_is_lower) begin
          o_byte = i_byte - DATA_BITS'(ASCII_CASE_DELTA);
        end
      end
      default:    o_byte = i_byte;
    endcase
  end

endmodule

// File: rtl/uart_echo_engine.sv
// RX-FIFO to TX-FIFO loopback controller with optional per-word transform,
// manual/continuous pacing, traffic counters and a sticky overrun flag.
module uart_echo_engine
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned CNT_BITS  = 16,
  parameter int unsigned OFFSET    = 1
) (
  input  logic                 clk_100MHz,
  input  logic                 reset_n,
  input  logic [MODE_BITS-1:0] mode,
  input  logic                 trig,
  input  logic                 rx_empty,
  input  logic                 rx_full,
  input  logic                 tx_full,
  input  logic [DATA_BITS-1:0] read_data,
  output logic                 read_uart,
  output logic                 write_uart,
  output logic [DATA_BITS-1:0] write_data,
  output logic [DATA_BITS-1:0] last_byte,
  output logic [CNT_BITS-1:0]  rx_count,
  output logic [CNT_BITS-1:0]  tx_count,
  output logic [CNT_BITS-1:0]  miss_count,
  output logic                 overrun,
  output logic                 busy
);

  state_t               r_state;
  logic [MODE_BITS-1:0] r_mode_q;
  logic                 r_read_uart;
  logic                 r_write_uart;
  logic [DATA_BITS-1:0] r_hold;
  logic [DATA_BITS-1:0] r_last_byte;
  logic [CNT_BITS-1:0]  r_rx_count;
  logic [CNT_BITS-1:0]  r_tx_count;
  logic [CNT_BITS-1:0]  r_miss_count;
  logic                 r_overrun;
  logic                 r_busy;

  logic [DATA_BITS-1:0] w_xform_byte;
  logic                 w_start;
  logic                 w_miss;

  // Transform the FIFO head while it is popped so the hold register already
  // carries the final word from XFORM onward.
  byte_xform #(
    .DATA_BITS (DATA_BITS),
    .OFFSET    (OFFSET)
  ) u_byte_xform (
    .i_mode (r_mode_q),
    .i_byte (read_data),
    .o_byte (w_xform_byte)
  );

  assign w_start = !rx_empty && ((mode != MODE_MANUAL) || trig);
  assign w_miss  = (mode == MODE_MANUAL) && trig && rx_empty;

  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_mode_q     <= MODE_MANUAL;
      r_read_uart  <= 1'b0;
      r_write_uart <= 1'b0;
      r_hold       <= '0;
      r_last_byte  <= '0;
      r_rx_count   <= '0;
      r_tx_count   <= '0;
      r_miss_count <= '0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_read_uart  <= 1'b0;
      r_write_uart <= 1'b0;

      if (rx_full && (r_mode_q != MODE_MANUAL)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          r_mode_q <= mode;
          if (w_start) begin
            r_state     <= ST_CAPTURE;
            r_read_uart <= 1'b1;
            r_busy      <= 1'b1;
          end else if (w_miss) begin
            r_miss_count <= r_miss_count + CNT_BITS'(1);
          end
        end
        ST_CAPTURE: begin
          r_last_byte <= read_data;
          r_hold      <= w_xform_byte;
          r_rx_count  <= r_rx_count + CNT_BITS'(1);
          r_state     <= ST_XFORM;
        end
        ST_XFORM, ST_WAIT_TX: begin
          if (!tx_full) begin
            r_state      <= ST_SEND;
            r_write_uart <= 1'b1;
          end else begin
            r_state <= ST_WAIT_TX;
          end
        end
        ST_SEND: begin
          r_tx_count <= r_tx_count + CNT_BITS'(1);
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign read_uart  = r_read_uart;
  assign write_uart = r_write_uart;
  assign write_data = r_hold;
  assign last_byte  = r_last_byte;
  assign rx_count   = r_rx_count;
  assign tx_count   = r_tx_count;
  assign miss_count = r_miss_count;
  assign overrun    = r_overrun;
  assign busy       = r_busy;

endmodule

// File: tb/tb_uart_echo_engine.sv
// Scoreboard bench for uart_echo_engine: a queue-based RX FIFO model feeds the
// DUT, expected TX words are queued at stimulus time and checked on write_uart.
module tb_uart_echo_engine;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  logic          clk_100MHz = 1'b0;
  logic          reset_n;
  logic [1:0]    mode;
  logic          trig;
  logic          rx_empty = 1'b1;
  logic          rx_full;
  logic          tx_full = 1'b0;
  logic [DW-1:0] read_data = '0;
  logic          read_uart;
  logic          write_uart;
  logic [DW-1:0] write_data;
  logic [DW-1:0] last_byte;
  logic [CW-1:0] rx_count;
  logic [CW-1:0] tx_count;
  logic [CW-1:0] miss_count;
  logic          overrun;
  logic          busy;

  always #5 clk_100MHz = ~clk_100MHz;

  uart_echo_engine #(.DATA_BITS(DW), .CNT_BITS(CW), .OFFSET(1)) dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .mode       (mode),
    .trig       (trig),
    .rx_empty   (rx_empty),
    .rx_full    (rx_full),
    .tx_full    (tx_full),
    .read_data  (read_data),
    .read_uart  (read_uart),
    .write_uart (write_uart),
    .write_data (write_data),
    .last_byte  (last_byte),
    .rx_count   (rx_count),
    .tx_count   (tx_count),
    .miss_count (miss_count),
    .overrun    (overrun),
    .busy       (busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rd_strobes = 0;
  int wr_strobes = 0;
  int last_rd_cyc = -1;
  int last_wr_cyc = -1;
  int exp_words = 0;
  int tx_ctl = 0;   // 0: tx_full low, 1: held high, 2: random backpressure
  logic [7:0] rx_q[$];
  logic [7:0] pend_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  bit pop_now;
  bit prev_rd = 1'b0;
  bit prev_wr = 1'b0;

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference transform straight from the mode definitions (OFFSET = 1, 8-bit).
  function automatic logic [7:0] ref_xform(int m, int b);
    int r;
    r = b;
    if (m == 2) r = (b + 1) % 256;
    else if (m == 3 && b >= 97 && b <= 122) r = b - 32;
    return 8'(r);
  endfunction

  always @(posedge clk_100MHz) cyc++;

  // RX FIFO model (first-word-fall-through) and tx_full driver.
  always @(posedge clk_100MHz) begin
    pop_now = (read_uart === 1'b1);
    #1;
    if (pop_now) begin
      if (rx_q.size() == 0) chk("rx_fifo_underflow", 1, 0);
      else void'(rx_q.pop_front());
    end
    while (pend_q.size() > 0) rx_q.push_back(pend_q.pop_front());
    rx_empty  = (rx_q.size() == 0);
    read_data = rx_empty ? '0 : rx_q[0];
    case (tx_ctl)
      1:       tx_full = 1'b1;
      2:       tx_full = ($urandom_range(0, 3) == 0);
      default: tx_full = 1'b0;
    endcase
  end

  // Monitor: strobe protocol and scoreboard comparison of every pushed word.
  always @(negedge clk_100MHz) begin
    if (read_uart === 1'b1) begin
      rd_strobes++;
      last_rd_cyc = cyc;
      chk("rd_back_to_back", int'(prev_rd), 0);
      chk("rd_wr_same_cycle", int'(write_uart === 1'b1), 0);
    end
    if (write_uart === 1'b1) begin
      wr_strobes++;
      last_wr_cyc = cyc;
      chk("wr_back_to_back", int'(prev_wr), 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("write_data", int'(write_data), int'(mon_exp));
      end
    end
    prev_rd = (read_uart === 1'b1);
    prev_wr = (write_uart === 1'b1);
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  task automatic push(logic [7:0] b, logic [7:0] e);
    pend_q.push_back(b);
    exp_q.push_back(e);
    exp_words++;
  endtask

  task automatic wait_idle(string name);
    int k;
    k = 0;
    while (k < 3000 && !(pend_q.size() == 0 && rx_q.size() == 0 &&
                         exp_q.size() == 0 && busy == 1'b0)) begin
      tick(1);
      k++;
    end
    chk({name, "_idle_timeout"}, int'(k >= 3000), 0);
    tick(2);
  endtask

  task automatic wait_rd(string name);
    int k;
    k = 0;
    tick(1);
    while (k < 500 && read_uart !== 1'b1) begin
      tick(1);
      k++;
    end
    chk({name, "_rd_timeout"}, int'(k >= 500), 0);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_read_uart"},  int'(read_uart), 0);
    chk({tag, "_write_uart"}, int'(write_uart), 0);
    chk({tag, "_write_data"}, int'(write_data), 0);
    chk({tag, "_last_byte"},  int'(last_byte), 0);
    chk({tag, "_rx_count"},   int'(rx_count), 0);
    chk({tag, "_tx_count"},   int'(tx_count), 0);
    chk({tag, "_miss_count"}, int'(miss_count), 0);
    chk({tag, "_overrun"},    int'(overrun), 0);
    chk({tag, "_busy"},       int'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, s_rd, s_wr, m, n;
    logic [7:0] v;
    reset_n = 1'b0;
    mode    = 2'd0;
    trig    = 1'b0;
    rx_full = 1'b0;
    tick(3);
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick(2);

    // MANUAL: word waits for the tick, then fixed latency
    push(8'h41, 8'h41);
    tick(20);
    chk("manual_rd_before_tick", rd_strobes, 0);
    chk("manual_wr_before_tick", wr_strobes, 0);
    t0 = cyc;
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    wait_idle("manual");
    chk("manual_rd_latency", last_rd_cyc - t0, 1);
    chk("manual_wr_latency", last_wr_cyc - t0, 3);
    chk("manual_rx_count", int'(rx_count), 1);
    chk("manual_tx_count", int'(tx_count), 1);

    // MANUAL with empty FIFO: ticks are counted as misses
    s_rd = rd_strobes;
    repeat (3) begin
      trig = 1'b1;
      tick(1);
      trig = 1'b0;
      tick(2);
    end
    chk("miss_count", int'(miss_count), 3);
    chk("miss_no_strobe", rd_strobes, s_rd);

    // ADD and UPPER streaming
    mode = 2'd2;
    tick(2);
    push(8'h30, 8'h31);
    push(8'hFF, 8'h00);
    wait_idle("add");
    mode = 2'd3;
    tick(2);
    push(8'h61, 8'h41);
    push(8'h7A, 8'h5A);
    push(8'h7B, 8'h7B);
    push(8'h40, 8'h40);
    wait_idle("upper");
    chk("stream_rx_count", int'(rx_count), exp_words);
    chk("stream_tx_count", int'(tx_count), exp_words);

    // ECHO with TX backpressure
    mode = 2'd1;
    tx_ctl = 1;
    tick(2);
    s_wr = wr_strobes;
    push(8'h5C, 8'h5C);
    wait_rd("bp");
    tick(12);
    chk("bp_busy_held", int'(busy), 1);
    chk("bp_no_write", wr_strobes, s_wr);
    tx_ctl = 0;
    wait_idle("bp");
    chk("bp_one_write", wr_strobes, s_wr + 1);
    chk("bp_last_byte", int'(last_byte), 8'h5C);

    // Sticky overrun
    chk("overrun_clear", int'(overrun), 0);
    rx_full = 1'b1;
    tick(1);
    rx_full = 1'b0;
    tick(3);
    chk("overrun_set", int'(overrun), 1);
    tick(10);
    chk("overrun_sticky", int'(overrun), 1);

    // Mode change while a word is in flight
    push(8'h61, 8'h61);
    wait_rd("modesw");
    mode = 2'd3;
    push(8'h62, 8'h42);
    wait_idle("modesw");

    // Reset while stalled in WAIT_TX
    mode = 2'd1;
    tick(2);
    tx_ctl = 1;
    tick(2);
    pend_q.push_back(8'hA5);
    wait_rd("rstwait");
    tick(3);
    s_wr = wr_strobes;
    reset_n = 1'b0;
    tick(1);
    chk_all_zero("midreset");
    reset_n = 1'b1;
    tx_ctl = 0;
    exp_words = 0;
    tick(10);
    chk("midreset_no_write", wr_strobes, s_wr);
    push(8'h33, 8'h33);
    wait_idle("postreset");
    chk("postreset_rx_count", int'(rx_count), 1);
    chk("postreset_tx_count", int'(tx_count), 1);

    // Randomized batches in the continuous modes
    for (int b = 0; b < 6; b++) begin
      m = int'($urandom_range(1, 3));
      mode = 2'(m);
      tx_ctl = (($urandom_range(0, 1) == 1) ? 2 : 0);
      tick(2);
      n = int'($urandom_range(3, 8));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) v = 8'($urandom_range(8'h5F, 8'h7C));
        else v = 8'($urandom_range(0, 255));
        push(v, ref_xform(m, int'(v)));
      end
      wait_idle("rand");
    end
    tx_ctl = 0;

    // Randomized MANUAL words, one tick each
    mode = 2'd0;
    tick(2);
    repeat (3) begin
      v = 8'($urandom_range(0, 255));
      push(v, ref_xform(0, int'(v)));
      tick(3);
      trig = 1'b1;
      tick(1);
      trig = 1'b0;
      wait_idle("rand_manual");
    end

    chk("final_rx_count", int'(rx_count), exp_words);
    chk("final_tx_count", int'(tx_count), exp_words);
    chk("final_scoreboard_empty", int'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
